// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector (pattern length 1..MAX_LEN, overlap select).
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1001,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x,
    input  logic               x_valid,
    input  logic               count_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               y_q, y_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W-1:0]   eff_len;
    logic [MAX_LEN-1:0] mask;
    logic               match;

    always_comb begin
        eff_len = (len_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(eff_len));
        end
        hist_n = {hist_q[MAX_LEN-2:0], x};
        fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        match  = 1'b0;
        if (cfg_load) begin
            // The bit on a load edge is dropped; the new pattern starts from an empty history.
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            match  = (eff_len != '0) && (fill_n >= eff_len) &&
                     (((hist_n ^ pat_q) & mask) == '0);
            y_d    = match;
            hist_d = hist_n;
            fill_d = (match && !ovl_q) ? '0 : fill_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= RST_PATTERN;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= RST_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
        end
    end

    assign y = y_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    logic cnt_unused;
    assign cnt_unused  = count_clr;
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: stimulus pushes model results, a monitor pops and compares.
module tb_seq_detector_prog;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               x;
    logic               x_valid;
    logic               count_clr;
    logic               y;
    logic [CNT_W-1:0]   match_count;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RST_PATTERN(8'b0000_1001),
                        .RST_LEN(4), .RST_OVERLAP(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x(x), .x_valid(x_valid),
        .count_clr(count_clr), .y(y), .match_count(match_count));

    always #5 clk = ~clk;

    typedef struct {
        logic             y;
        logic [CNT_W-1:0] cnt;
        int               idx;
    } exp_t;

    exp_t expq[$];
    event chk_ev;
    int   checks = 0, failures = 0, pushed = 0, popped = 0;

    // Reference model: raw bit history since the last clear, pattern compared bit by bit.
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 m_bits[$];
    int                 m_cnt;

    function automatic void model_reset();
        m_pat = 8'b0000_1001;
        m_len = 4;
        m_ovl = 1'b1;
        m_bits.delete();
        m_cnt = 0;
    endfunction

    function automatic bit model_step(bit ld, logic [MAX_LEN-1:0] p, int ln, bit ov,
                                      bit xb, bit xv, bit clr);
        bit match = 1'b0;
        bit yv    = 1'b0;
        int l;
        if (ld) begin
            m_pat = p;
            m_len = ln;
            m_ovl = ov;
            m_bits.delete();
        end else if (xv) begin
            m_bits.push_back(xb);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            l = (m_len > MAX_LEN) ? MAX_LEN : m_len;
            if (l != 0 && m_bits.size() >= l) begin
                match = 1'b1;
                for (int j = 0; j < l; j++)
                    if (m_bits[m_bits.size() - 1 - j] != m_pat[j]) match = 1'b0;
            end
            yv = match;
            if (match && !m_ovl) m_bits.delete();
        end
`ifdef SEQDET_COUNT_EN
        if (clr) m_cnt = 0;
        else if (match && m_cnt < CNT_MAX) m_cnt++;
`endif
        return yv;
    endfunction

    task automatic push_exp(bit yv);
        exp_t e;
        e.y   = yv;
        e.cnt = CNT_W'(m_cnt);
        e.idx = pushed;
        expq.push_back(e);
        pushed++;
    endtask

    task automatic drive(bit ld, logic [MAX_LEN-1:0] p, int ln, bit ov, bit xb, bit xv, bit clr);
        bit yv;
        @(negedge clk);
        cfg_load = ld; cfg_pattern = p; cfg_len = LEN_W'(ln); cfg_overlap = ov;
        x = xb; x_valid = xv; count_clr = clr;
        yv = model_step(ld, p, ln, ov, xb, xv, clr);
        push_exp(yv);
    endtask

    task automatic send(bit b);
        drive(1'b0, '0, 0, 1'b0, b, 1'b1, 1'b0);
    endtask

    task automatic send_bits(logic [15:0] bits, int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    task automatic gap();
        drive(1'b0, '0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic load(logic [MAX_LEN-1:0] p, int ln, bit ov, bit xb);
        drive(1'b1, p, ln, ov, xb, 1'b1, 1'b0);
    endtask

    // Reset lands mid low-phase; the monitor checks before the next rising edge.
    task automatic do_reset();
        @(negedge clk);
        cfg_load = 1'b0; x_valid = 1'b0; count_clr = 1'b0; x = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        push_exp(1'b0);
        -> chk_ev;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                popped++;
                checks++;
                if (y !== e.y) begin
                    failures++;
                    $display("FAIL y step=%0d got=%b want=%b", e.idx, y, e.y);
                end
                checks++;
                if (match_count !== e.cnt) begin
                    failures++;
                    $display("FAIL match_count step=%0d got=%0d want=%0d", e.idx, match_count, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int wait_cyc;
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        x = 1'b0; x_valid = 1'b0; count_clr = 1'b0;
        model_reset();
        do_reset();

        // Defaults, overlapping: pulses after bits 4 and 7
        send_bits(16'b1001001, 7);
        // Non-overlapping
        load(8'b1001, 4, 1'b0, 1'b0);
        send_bits(16'b1001001, 7);
        send_bits(16'b10011001, 8);
        // Load edge discards x; partial history cleared
        send_bits(16'b11, 2);
        load(8'b110, 3, 1'b1, 1'b1);
        send(1'b0);
        send_bits(16'b110, 3);
        // Gaps in x_valid
        load(8'b1001, 4, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            send(i == 3 || i == 0);
            repeat (3) gap();
        end
        // Back-to-back matches, counter saturation, clear beats match
        load(8'b11, 2, 1'b1, 1'b0);
        repeat (6) send(1'b1);
        drive(1'b0, '0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(1'b1);
        // Reset mid-stream
        do_reset();
        send_bits(16'b100, 3);
        do_reset();
        send(1'b1);
        send_bits(16'b001, 3);
        // Length 0 disables detection
        load(8'hFF, 0, 1'b1, 1'b0);
        repeat (12) send(1'($urandom_range(0, 1)));

        // Random traffic with occasional reconfiguration and clears
        for (int i = 0; i < 800; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 4)
                load(8'($urandom), $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            else
                drive(1'b0, '0, 0, 1'b0, 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 29) == 0));
            if (i % 200 == 199) do_reset();
        end

        wait_cyc = 0;
        while (expq.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        checks++;
        if (popped != pushed) begin
            failures++;
            $display("FAIL scoreboard_drain popped=%0d want=%0d", popped, pushed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Programmable Moore-style serial sequence detector for pattern lengths 1..MAX_LEN, with runtime-selectable overlapping or non-overlapping detection, a qualified input strobe and an optional saturating match counter. It replaces fixed-pattern, hand-coded detector FSMs. A pattern change is a register write, not an RTL edit. It sits on any serial bit stream (framing/sync-word search) and drives a registered, glitch-free match flag.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN)+1: width of the length field.
- RST_PATTERN, 8'b0000_1001: pattern loaded at reset (LSB-aligned).
- RST_LEN, 4: length loaded at reset.
- RST_OVERLAP, 1: overlap mode loaded at reset.
- CNT_W, 8: match counter width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this edge.
- cfg_pattern  in  MAX_LEN  pattern; bit len-1 = first bit received, bit 0 = last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- x  in  1  serial data bit.
- x_valid  in  1  x sampled only when high.
- count_clr  in  1  synchronous clear of match_count.
- y  out  1  registered match flag (Moore output).
- match_count  out  CNT_W  saturating number of matches.

## Operation
- State: pat[MAX_LEN-1:0], len, ovl (config regs); hist[MAX_LEN-1:0] (newest bit in bit 0); fill (0..MAX_LEN, valid bits since last clear, saturating at MAX_LEN); y; match_count.
- Effective length L = min(len, MAX_LEN). If len == 0, the detector is disabled and y never asserts.
- On an edge with x_valid=1 and cfg_load=0: hist_n = {hist[MAX_LEN-2:0], x}, fill_n = min(fill+1, MAX_LEN).
- match = (L != 0) && (fill_n >= L) && (hist_n[L-1:0] == pat[L-1:0]).
- Overlapping mode: hist and fill advance normally after a match, so a pattern suffix can start the next match.
- Non-overlapping mode: on a match, fill is cleared to 0, so the next match needs L fresh bits.
- y is updated every edge: y <= match when x_valid=1, otherwise y <= 0. Each match produces exactly one one-cycle pulse.
- cfg_load has priority over x_valid. On a load edge:
  - pat, len and ovl are latched.
  - hist, fill and y are cleared.
  - The x on that edge is discarded.
  - match_count is not affected.
- Counter behaviour:
  - match_count increments on each match and holds at 2^CNT_W-1.
  - count_clr forces it to 0 and wins over a simultaneous match.
- Reset values: pat=RST_PATTERN, len=RST_LEN, ovl=RST_OVERLAP, hist=0, fill=0, y=0, match_count=0.

## Timing
- Latency: the bit completing the pattern is sampled at edge k. y is high from edge k until edge k+1.
- y depends only on registered state and has no combinational path from x.
- Back-to-back matches (e.g. pattern 11, L=2, overlapping, x=1 every cycle) give y held high for consecutive cycles. Each of those cycles counts as one match.
- Gaps in x_valid neither break a partial match nor advance it.
- Reset asserted mid-stream returns all state to reset values immediately (asynchronous). The first match is possible only after L valid bits following release.
- New configuration takes effect for bits sampled on the edge after cfg_load.

## Configuration
- SEQDET_COUNT_EN defined: match_count register and count_clr are implemented as described above.
- SEQDET_COUNT_EN undefined: no counter flops. match_count is driven constant 0 and count_clr is ignored. y behaviour is identical in both builds.

## Test plan
- Reset defaults (pattern 1001, L=4, overlapping), stream 1,0,0,1,0,0,1 -> y pulses after bit 4 and bit 7; match_count=2.
- Load cfg_overlap=0, same stream 1,0,0,1,0,0,1 -> single pulse after bit 4. Stream 1,0,0,1,1,0,0,1 -> pulses after bits 4 and 8.
- Send 1,1 then cfg_load of pattern 110 with L=3 (x=1 on the load edge), then 0 -> no pulse. Then send 1,1,0 -> pulse after the final 0.
- Pattern 1001 with x_valid low for 3 cycles between every bit -> one pulse after the 4th valid bit. y is low during all gap cycles.
- CNT_W=2, pattern 11, L=2, overlapping, six 1s -> count saturates at 3. count_clr together with a match -> count=0. Build without SEQDET_COUNT_EN -> match_count stays 0.
- Assert rst after 1,0,0 of pattern 1001, release, then send 1 -> no pulse. Then send 0,0,1 -> pulse. cfg_len=0 with any stream -> y stays 0.
